// File: rtl/multdiv_unit.sv
// Iterative multiply/divide responder for the MIPS execute stage: 2-stage multiply, restoring divide.
// Define MULTDIV_DIV_EARLY_EN to compile in the divide early-out (zero divisor or |a| < |b|).
module multdiv_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_multdiv,
    input  logic [3:0]  multicycle_type,
    input  logic        stallE,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        ok
);
    localparam int CW = $clog2(DIV_ITERS) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;     // original a, needed for the divide-by-zero hi value
    logic [31:0]   b_q, b_d;     // raw b for multiply, |b| for divide
    logic          signed_q, signed_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic [31:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d;
    logic [49:0]   pp0_q, pp0_d;
    logic [47:0]   pp1_q, pp1_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          req_div, req_signed, early;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   a_x, b_x;
    logic [49:0]   pp0_c;
    logic [47:0]   pp1_c;
    logic [63:0]   prod;
    logic [32:0]   shifted;
    logic [31:0]   diff;
    logic          fits;
    logic [31:0]   quo_fix, rem_fix;

    always_comb begin
        req_div    = 1'b0;
        req_signed = 1'b0;
        case (multicycle_type)
            4'd1, 4'd5, 4'd7: req_signed = 1'b1;
            4'd3: begin
                req_div    = 1'b1;
                req_signed = 1'b1;
            end
            4'd4:    req_div = 1'b1;
            default: req_signed = 1'b0;
        endcase
    end

    assign a_mag = (req_signed && a[31]) ? 32'd0 - a : a;
    assign b_mag = (req_signed && b[31]) ? 32'd0 - b : b;

`ifdef MULTDIV_DIV_EARLY_EN
    assign early = (b_mag == 32'd0) || (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // 33-bit extended operands; b split into an unsigned low half and a signed high part
    assign a_x   = {signed_q & a_q[31], a_q};
    assign b_x   = {signed_q & b_q[31], b_q};
    assign pp0_c = {{17{a_x[32]}}, a_x} * {34'd0, b_x[15:0]};
    assign pp1_c = {{15{a_x[32]}}, a_x} * {{31{b_x[32]}}, b_x[32:16]};
    assign prod  = {{14{pp0_q[49]}}, pp0_q} + {pp1_q, 16'd0};

    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, b_q};
    assign diff    = shifted[31:0] - b_q;

    assign quo_fix = (sign_a_q ^ sign_b_q) ? 32'd0 - quo_q : quo_q;
    assign rem_fix = sign_a_q ? 32'd0 - rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        pp0_d    = pp0_q;
        pp1_d    = pp1_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_multdiv) begin
                        a_d      = a;
                        signed_d = req_signed;
                        if (req_div) begin
                            b_d      = b_mag;
                            sign_a_d = req_signed & a[31];
                            sign_b_d = req_signed & b[31];
                            if (early) begin
                                rem_d   = a_mag;
                                quo_d   = 32'd0;
                                state_d = S_FIX;
                            end else begin
                                rem_d   = 32'd0;
                                quo_d   = a_mag;
                                cnt_d   = CW'(DIV_ITERS - 1);
                                state_d = S_DIV;
                            end
                        end else begin
                            b_d      = b;
                            sign_a_d = 1'b0;
                            sign_b_d = 1'b0;
                            cnt_d    = CW'(1);
                            state_d  = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q != '0) begin
                        pp0_d = pp0_c;
                        pp1_d = pp1_c;
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_d = S_DONE;
                    end
                end
                S_DIV: begin
                    rem_d = fits ? diff : shifted[31:0];
                    quo_d = {quo_q[30:0], fits};
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    if (b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (!(stallE && is_multdiv)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            pp0_q    <= '0;
            pp1_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            pp0_q    <= pp0_d;
            pp1_q    <= pp1_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign ok = (state_q == S_IDLE) ? ~is_multdiv : (state_q == S_DONE);
    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table with a result scoreboard plus
// hand sequences for operand changes, flush, async reset, stall and back-to-back requests.
module tb_multdiv_unit;
    localparam int DIV_ITERS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic        is_multdiv;
    logic [3:0]  multicycle_type;
    logic        stallE, flush;
    logic [31:0] hi, lo;
    logic        ok;

    multdiv_unit #(.DIV_ITERS(DIV_ITERS)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .is_multdiv(is_multdiv),
        .multicycle_type(multicycle_type), .stallE(stallE), .flush(flush),
        .hi(hi), .lo(lo), .ok(ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] x, y, ehi, elo;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          lat;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: 64-bit host arithmetic, MIPS divide-by-zero rule
    function automatic logic [63:0] model(logic [3:0] t, logic [31:0] x, logic [31:0] y);
        longint      sx, sy, q, m;
        logic [63:0] ux, uy, uq, um, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (t)
            4'd1, 4'd5, 4'd7: r = sx * sy;
            4'd3: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            4'd4: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    uq = ux / uy;
                    um = ux % uy;
                    r  = {um[31:0], uq[31:0]};
                end
            end
            default: r = ux * uy;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(logic [3:0] t, logic [31:0] x, logic [31:0] y);
`ifdef MULTDIV_DIV_EARLY_EN
        logic [31:0] ax, by;
`endif
        if (t != 4'd3 && t != 4'd4) return 3;
`ifdef MULTDIV_DIV_EARLY_EN
        ax = (t == 4'd3 && x[31]) ? 32'd0 - x : x;
        by = (t == 4'd3 && y[31]) ? 32'd0 - y : y;
        if (y == 32'd0 || ax < by) return 2;
`endif
        return DIV_ITERS + 2;
    endfunction

    task automatic drive(logic [3:0] t, logic [31:0] x, logic [31:0] y);
        multicycle_type = t;
        a               = x;
        b               = y;
        is_multdiv      = 1'b1;
    endtask

    task automatic issue(logic [3:0] t, logic [31:0] x, logic [31:0] y,
                         logic [31:0] ehi, logic [31:0] elo, string name);
        exp_t e;
        drive(t, x, y);
        e.hi = ehi; e.lo = elo; e.lat = exp_lat(t, x, y); e.name = name;
        sb.push_back(e);
        #1;
        check({name, " ok@C0"}, {63'd0, ok}, 64'd0);
    endtask

    task automatic wait_ok(input int start, output int lat);
        lat = start;
        while (!ok && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_op(int lat);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: result seen with no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: ok still 0 after %0d cycles, required %0d", e.name, lat, e.lat);
        end else begin
            check({e.name, " latency"}, 64'(lat), 64'(e.lat));
        end
        check({e.name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({e.name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
    endtask

    task automatic release_req();
        is_multdiv = 1'b0;
        step();
    endtask

    task automatic run_vec(vec_t v);
        int lat;
        issue(v.t, v.x, v.y, v.ehi, v.elo, v.name);
        wait_ok(0, lat);
        finish_op(lat);
        release_req();
    endtask

    task automatic add_vec(logic [3:0] t, logic [31:0] x, logic [31:0] y,
                           logic [31:0] ehi, logic [31:0] elo, string name);
        vec_t v;
        v.t = t; v.x = x; v.y = y; v.ehi = ehi; v.elo = elo; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rtypes[6];
        logic [31:0] rx, ry;
        logic [63:0] r;
        int          lat;
        logic        ok_low;

        reset = 1'b1; a = '0; b = '0; is_multdiv = 1'b0;
        multicycle_type = '0; stallE = 1'b0; flush = 1'b0;

        // fixed vectors with hand-derived results
        add_vec(4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3");
        add_vec(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        add_vec(4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        add_vec(4'd4, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, "divu_by0");
        add_vec(4'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0");
        add_vec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        add_vec(4'd5, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "madd_min2");
        add_vec(4'd8, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000, "msubu");
        add_vec(4'd7, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, "msub");
        add_vec(4'd0, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, "none_as_multu");
        add_vec(4'd6, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, "maddu");
        add_vec(4'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, "divu_100_7");
        add_vec(4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
        add_vec(4'd3, 32'd3,         32'd10,        32'h0000_0003, 32'h0000_0000, "div_small");
        add_vec(4'd3, 32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 32'h0000_0000, "div_small_neg");
        add_vec(4'd4, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, "divu_by1");
        add_vec(4'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7_m1");

        rtypes[0] = 4'd1; rtypes[1] = 4'd2; rtypes[2] = 4'd3;
        rtypes[3] = 4'd4; rtypes[4] = 4'd5; rtypes[5] = 4'd8;
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = (i == 2 || i == 3) ? 32'($urandom_range(1, 5000)) : $urandom;
            r  = model(rtypes[i], rx, ry);
            add_vec(rtypes[i], rx, ry, r[63:32], r[31:0], $sformatf("rand%0d", i));
        end

        // reset state
        step(); step();
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset ok idle", {63'd0, ok}, 64'd1);
        is_multdiv = 1'b1; #1;
        check("reset ok req", {63'd0, ok}, 64'd0);
        is_multdiv = 1'b0;
        reset = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // operand change after capture is ignored
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_opchange");
        for (int i = 0; i < 5; i++) step();
        a = 32'd123; b = 32'd9;
        wait_ok(5, lat);
        finish_op(lat);
        release_req();

        // known prior result, then flush at C10 of a divide
        issue(4'd2, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 32'hFFFF_FFFD, "prior_multu");
        wait_ok(0, lat);
        finish_op(lat);
        release_req();
        drive(4'd4, 32'd100, 32'd3);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1; is_multdiv = 1'b0;
        step();
        flush = 1'b0; #1;
        check("flush idle ok", {63'd0, ok}, 64'd1);
        ok_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!ok) ok_low = 1'b1;
        end
        check("flush no resume", {63'd0, ok_low}, 64'd0);
        check("flush hi kept", {32'd0, hi}, 64'h2);
        check("flush lo kept", {32'd0, lo}, 64'hFFFF_FFFD);

        // request arriving together with flush is not started
        drive(4'd4, 32'd9, 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0; is_multdiv = 1'b0; #1;
        ok_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!ok) ok_low = 1'b1;
            step();
        end
        check("flush req dropped", {63'd0, ok_low}, 64'd0);
        check("flush req lo", {32'd0, lo}, 64'hFFFF_FFFD);

        // async reset at C10 of a divide
        drive(4'd3, 32'd100, 32'd3);
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1; #1;
        check("midreset hi", {32'd0, hi}, 64'd0);
        check("midreset lo", {32'd0, lo}, 64'd0);
        check("midreset ok req", {63'd0, ok}, 64'd0);
        is_multdiv = 1'b0; #1;
        check("midreset ok idle", {63'd0, ok}, 64'd1);
        step();
        reset = 1'b0;
        step();
        check("postreset ok", {63'd0, ok}, 64'd1);
        check("postreset lo", {32'd0, lo}, 64'd0);

        // stall holds DONE, then back-to-back MULTU
        issue(4'd1, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FF00, "mult_stall");
        wait_ok(0, lat);
        finish_op(lat);
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall ok %0d", i), {63'd0, ok}, 64'd1);
            check($sformatf("stall hi %0d", i), {32'd0, hi}, 64'hFFFF_FFFF);
            check($sformatf("stall lo %0d", i), {32'd0, lo}, 64'hFFFF_FF00);
        end
        stallE = 1'b0;
        multicycle_type = 4'd2; a = 32'h1234_5678; b = 32'h100;
        begin
            exp_t e;
            e.hi = 32'h0000_0012; e.lo = 32'h3456_7800; e.lat = 3; e.name = "b2b_multu";
            sb.push_back(e);
        end
        step();
        check("b2b ok@C0", {63'd0, ok}, 64'd0);
        check("b2b hi held", {32'd0, hi}, 64'hFFFF_FFFF);
        wait_ok(0, lat);
        finish_op(lat);
        release_req();

        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative multiply/divide responder for the MIPS execute stage. It accepts a request held on `is_multdiv`/`multicycle_type`, computes the 64-bit `{hi, lo}` result and raises `ok` when that result is valid. The execute stage stalls on `!ok` and adds or subtracts its accumulator itself for MADD/MSUB. This block only supplies the raw product.

## Interface
- `DIV_ITERS`, default 32: restoring-divide iterations; must equal the operand width.
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-high reset.
- `a  in  32`: operand A (multiplicand or dividend).
- `b  in  32`: operand B (multiplier or divisor).
- `is_multdiv  in  1`: request is valid. Held high until consumed.
- `multicycle_type  in  4`: operation code.
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU.
  - 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU.
- `stallE  in  1`: execute stage held this cycle; the result must be kept.
- `flush  in  1`: abort the in-flight operation.
- `hi  out  32`: product[63:32] or remainder.
- `lo  out  32`: product[31:0] or quotient.
- `ok  out  1`: result valid, or no request pending.

## Operation
- Signedness:
  - MULT, DIV, MADD and MSUB are signed.
  - MULTU, DIVU, MADDU and MSUBU are unsigned.
  - MADD through MSUBU compute exactly like MULT/MULTU.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - `ok = ~is_multdiv`.
  - On `is_multdiv`, latch `a`, `b` and the type. Later operand changes (forwarding updates) are ignored.
  - Multiply types go to MUL with a 2-stage counter.
  - Divide types go to DIV. Operands are captured as magnitudes and the signs are recorded.
- MUL:
  - Two registered stages: 16×32 partial products, then sum.
  - Operands are sign- or zero-extended to 33 bits.
  - Then go to DONE.
- DIV:
  - One restoring step per cycle: remainder shift, trial subtract of |b|, quotient bit.
  - After `DIV_ITERS` steps, go to FIX.
- FIX:
  - Signed ops: negate the quotient if `sign(a)^sign(b)`; negate the remainder if `sign(a)`.
  - Divisor zero, any signedness: `lo=0xFFFFFFFF`, `hi=a` (the original operand).
  - Go to DONE.
- DONE:
  - `hi` and `lo` are updated on entry and `ok=1`.
  - Stay in DONE while `stallE && is_multdiv`; otherwise go to IDLE.
  - A back-to-back request in the next cycle starts fresh from IDLE.
- `hi`/`lo` are registers. They change only on entry to DONE and hold between operations.
- `flush` (synchronous, highest priority after reset):
  - Next state is IDLE.
  - The operation is discarded and `hi`/`lo` are unchanged.
  - A request present in the same cycle as `flush` is not started.
- Type NONE with `is_multdiv=1`: treated as MULTU.
- Signed overflow:
  - `0x80000000 / -1` gives `lo=0x80000000`, `hi=0`.
  - Products are exact 64-bit with no overflow.

## Timing
- C0 is the first cycle `is_multdiv=1` is seen in IDLE. `ok` is combinational from state and `is_multdiv`.
- Multiply: ok in C3 (C1, C2 are the MUL stages).
- Divide: ok in C(DIV_ITERS+2), i.e. C34. Steps run C1..C32 and FIX runs in C33.
- `ok` is high for exactly one cycle unless `stallE` extends DONE.
- Reset, async and at any point including mid-operation:
  - state IDLE, counters 0, `hi=0`, `lo=0`.
  - Therefore `ok=~is_multdiv` during and after reset.

## Configuration
- `MULTDIV_DIV_EARLY_EN`: compiles in the divide early-out.
- Defined:
  - In C0, if `b==0` or `|a|<|b|`, skip DIV and go to FIX.
  - The quotient is 0 (or the divide-by-zero override) and the remainder is `a`.
  - `ok` rises in C2.
- Undefined: every divide takes the full `DIV_ITERS+2` cycles. Results are identical either way.

## Test plan
- MULT `a=0xFFFFFFFE`, `b=3` -> ok at C3, `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA`.
- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` -> ok at C3, `hi=0xFFFFFFFE`, `lo=0x00000001`.
- DIV `a=-7`, `b=2` -> ok at C34 (early-out off), `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - Change `a` at C5 -> result unchanged.
- DIVU `a=5`, `b=0` -> `lo=0xFFFFFFFF`, `hi=5`.
  - With `MULTDIV_DIV_EARLY_EN`, ok at C2.
- Abort cases:
  - DIV started, `flush` at C10 -> IDLE next cycle, `hi`/`lo` keep prior values.
  - Separately, `reset` at C10 -> `hi=lo=0`.
- MULT done with `stallE=1` for 3 cycles -> `ok` stays 1 and `hi`/`lo` are stable.
  - Then a back-to-back MULTU request gives `ok=0` on the following cycle and ok 3 cycles later.
